// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined core's MEM stage.
// Byte-addressable little-endian doubleword RAM behind a valid/ready request
// port, with a single-cycle response pulse after a fixed latency.
// Optional build macro: DMEM_SIGN_EXT_EN enables signed sub-dword loads
// (req_unsigned selects zero-extension); without it, all loads zero-extend.
module data_mem_responder #(
  parameter int DEPTH_DW     = 64,
  parameter int READ_LATENCY = 2,
  parameter int ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int                IDX_W      = $clog2(DEPTH_DW);
  localparam logic [ADDR_W-1:0] BYTE_LIMIT = ADDR_W'(DEPTH_DW * 8);
  localparam logic [2:0]        LAT_INIT   = 3'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_ACK} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [63:0] pend_data;
  logic        pend_err;
  logic [63:0] mem [DEPTH_DW];

  logic [IDX_W-1:0] idx;
  logic [5:0]       shamt;
  logic [63:0]      size_mask;
  logic             misaligned;
  logic             out_of_range;
  logic             acc_err;
  logic [63:0]      cur_dw;
  logic [63:0]      load_raw;
  logic [63:0]      load_ext;
  logic [63:0]      wr_mask;
  logic [63:0]      wr_data;

  assign req_ready = (state == IDLE);
  assign busy      = ~req_ready;

  assign idx   = req_addr[3 +: IDX_W];
  assign shamt = {req_addr[2:0], 3'b000};

  // Request decode: lane mask, alignment/range check and load data extraction
  always_comb begin
    size_mask  = '0;
    misaligned = 1'b0;
    case (req_size)
      2'd0: size_mask = 64'h0000_0000_0000_00FF;
      2'd1: begin
        size_mask  = 64'h0000_0000_0000_FFFF;
        misaligned = req_addr[0];
      end
      2'd2: begin
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        misaligned = |req_addr[1:0];
      end
      default: begin
        size_mask  = '1;
        misaligned = |req_addr[2:0];
      end
    endcase
    out_of_range = (req_addr >= BYTE_LIMIT);
    acc_err      = out_of_range | misaligned;
    cur_dw       = mem[idx];
    load_raw     = (cur_dw >> shamt) & size_mask;
    wr_mask      = size_mask << shamt;
    wr_data      = req_wdata << shamt;
  end

`ifdef DMEM_SIGN_EXT_EN
  logic sign_bit;

  // Sign bit of the loaded field; dword loads never need extension
  always_comb begin
    sign_bit = 1'b0;
    case (req_size)
      2'd0:    sign_bit = load_raw[7];
      2'd1:    sign_bit = load_raw[15];
      2'd2:    sign_bit = load_raw[31];
      default: sign_bit = 1'b0;
    endcase
  end

  assign load_ext = (!req_unsigned && sign_bit) ? (load_raw | ~size_mask) : load_raw;
`else
  logic unused_unsigned;

  assign unused_unsigned = req_unsigned;
  assign load_ext        = load_raw;
`endif

  // Request FSM; load data is extracted at accept so the response reflects
  // RAM contents at that edge even if later stores touch the same word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_data  <= '0;
      pend_err   <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_DW; i++) begin
        mem[i] <= '0;
      end
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            pend_err  <= acc_err;
            pend_data <= acc_err ? '0 : load_ext;
            if (req_write) begin
              if (!acc_err) begin
                mem[idx] <= (cur_dw & ~wr_mask) | (wr_data & wr_mask);
              end
              state <= WR_ACK;
            end else begin
              cnt   <= LAT_INIT;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == 3'd0) begin
            resp_valid <= 1'b1;
            resp_rdata <= pend_data;
            resp_err   <= pend_err;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WR_ACK: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          resp_err   <= pend_err;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus
// randomized load/store traffic against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH_DW     = 64;
  localparam int READ_LATENCY = 2;
  localparam int ADDR_W       = 64;
  localparam int BYTES        = DEPTH_DW * 8;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref_mem [BYTES];

  data_mem_responder #(
    .DEPTH_DW    (DEPTH_DW),
    .READ_LATENCY(READ_LATENCY),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
  endfunction

  // Architectural reference: access = size bytes starting at addr
  function automatic void model(input logic wr, input logic [63:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [63:0] wdata,
                                output logic err, output logic [63:0] rdata);
    int n;
    int base;
    n     = 1 << size;
    err   = (addr >= 64'(BYTES)) || (addr % 64'(n) != 0);
    rdata = '0;
    if (err) return;
    base = int'(addr[15:0]);
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[base + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) rdata[8*i +: 8] = ref_mem[base + i];
`ifdef DMEM_SIGN_EXT_EN
      if (!uns && n < 8 && rdata[8*n-1]) rdata = rdata | (~64'd0 << (8*n));
`else
      if (uns) rdata = rdata;
`endif
    end
  endfunction

  // Drive one request from a negedge, wait for its response; returns at the
  // response negedge so a following call is accepted in the response cycle
  task automatic issue(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata, output logic [63:0] got);
    logic        exp_err;
    logic [63:0] exp_data;
    int          n;
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_at_issue", 64'(req_ready), 64'd1);
    @(posedge clk);
    model(wr, addr, size, uns, wdata, exp_err, exp_data);
    @(negedge clk);
    req_valid    = 1'b0;
    req_write    = 1'($urandom);
    req_addr     = {$urandom, $urandom};
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 20) begin
      check("ready_low_while_busy", {63'd0, req_ready}, 64'd0);
      check("busy_high", {63'd0, busy}, 64'd1);
      @(negedge clk);
      n++;
    end
    check(wr ? "store_latency" : "load_latency", 64'(n), wr ? 64'd1 : 64'(READ_LATENCY));
    check("resp_valid", {63'd0, resp_valid}, 64'd1);
    check(wr ? "store_rdata" : "load_rdata", resp_rdata, wr ? 64'd0 : exp_data);
    check("resp_err", {63'd0, resp_err}, {63'd0, exp_err});
    check("ready_in_resp_cycle", {63'd0, req_ready}, 64'd1);
    check("busy_low_in_resp_cycle", {63'd0, busy}, 64'd0);
    got = resp_rdata;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("no_resp_when_idle", {63'd0, resp_valid}, 64'd0);
      check("ready_when_idle", {63'd0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] addr;
    logic        wr;
    logic [1:0]  size;
    int          n;

    reset        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    clear_model();
    repeat (2) @(negedge clk);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    idle(1);

    // Commit a store, then abort a load with reset: RAM clears, no response
    issue(1'b1, 64'h0, 2'd3, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, got);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h0; req_size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 2; i++) begin
      check("no_resp_during_reset", {63'd0, resp_valid}, 64'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_resp_after_abort", {63'd0, resp_valid}, 64'd0);
      check("ready_after_reset", {63'd0, req_ready}, 64'd1);
      check("busy_after_reset", {63'd0, busy}, 64'd0);
    end
    issue(1'b0, 64'h0, 2'd3, 1'b0, 64'h0, got);
    check("ram_cleared_by_reset", got, 64'd0);

    // Dword store/load and byte-lane merging
    issue(1'b1, 64'h08, 2'd3, 1'b0, 64'h1122_3344_5566_7788, got);
    issue(1'b0, 64'h08, 2'd3, 1'b0, 64'h0, got);
    check("dword_roundtrip", got, 64'h1122_3344_5566_7788);
    issue(1'b1, 64'h0B, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAA, got);
    issue(1'b0, 64'h08, 2'd3, 1'b0, 64'h0, got);
    check("byte_lane_merge", got, 64'h1122_3344_AA66_7788);
    issue(1'b0, 64'h0A, 2'd1, 1'b1, 64'h0, got);
    check("half_load", got, 64'h0000_0000_0000_AA66);
    issue(1'b0, 64'h0B, 2'd0, 1'b0, 64'h0, got);
`ifdef DMEM_SIGN_EXT_EN
    check("byte_signed", got, 64'hFFFF_FFFF_FFFF_FFAA);
`else
    check("byte_signed", got, 64'h0000_0000_0000_00AA);
`endif
    issue(1'b0, 64'h0B, 2'd0, 1'b1, 64'h0, got);
    check("byte_unsigned", got, 64'h0000_0000_0000_00AA);

    // Errors: misaligned load, out-of-range store leaves top word intact
    issue(1'b1, 64'h1F8, 2'd3, 1'b0, 64'hCAFE_0000_1234_5678, got);
    issue(1'b0, 64'h06, 2'd2, 1'b0, 64'h0, got);
    issue(1'b1, 64'h200, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, got);
    issue(1'b0, 64'h1F8, 2'd3, 1'b0, 64'h0, got);
    check("oor_store_no_effect", got, 64'hCAFE_0000_1234_5678);

    // Back-to-back store then load of the same address
    issue(1'b1, 64'h10, 2'd3, 1'b0, 64'h0F0E_0D0C_0B0A_0908, got);
    issue(1'b0, 64'h10, 2'd3, 1'b0, 64'h0, got);
    check("b2b_load_sees_store", got, 64'h0F0E_0D0C_0B0A_0908);
    idle(1);

    // Randomized traffic, concentrated on a small window for address reuse
    for (int t = 0; t < 400; t++) begin
      wr   = 1'($urandom);
      size = 2'($urandom);
      n    = $urandom_range(0, 15);
      if (n == 0)      addr = 64'(BYTES) + 64'($urandom_range(0, 64));
      else if (n == 1) addr = {$urandom, $urandom};
      else if (n < 8)  addr = 64'($urandom_range(0, 63));
      else             addr = 64'($urandom_range(0, BYTES - 1));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
      issue(wr, addr, size, 1'($urandom), {$urandom, $urandom}, got);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
